// File: rtl/sensor_hub_pkg.sv
// Shared register map for the sensor frame hub: word addresses and
// bit positions of the STATUS, CTRL and CLEAR registers.
package sensor_hub_pkg;

    localparam logic [5:0] ADDR_STATUS   = 6'd0;
    localparam logic [5:0] ADDR_CTRL     = 6'd1;
    localparam logic [5:0] ADDR_CLEAR    = 6'd2;
    localparam logic [5:0] ADDR_POP      = 6'd3;
    localparam logic [5:0] ADDR_DROP_CNT = 6'd4;
    localparam logic [5:0] ADDR_OUT0     = 6'd16;
    localparam logic [5:0] ADDR_FRAME0   = 6'd32;

    // STATUS: [7:0] level, then flag bits
    localparam int unsigned ST_EMPTY = 8;
    localparam int unsigned ST_FULL  = 9;
    localparam int unsigned ST_OVF   = 10;
    localparam int unsigned ST_UDF   = 11;

    localparam int unsigned CTRL_CAP_EN     = 0;
    localparam int unsigned CTRL_THRESH_LSB = 8;

    localparam int unsigned CLR_OVF  = 0;
    localparam int unsigned CLR_UDF  = 1;
    localparam int unsigned CLR_DROP = 2;

endpackage

// File: rtl/sync_frame_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty
// and a level output derived from extended read/write pointers.
module sync_frame_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_nxt, rd_nxt;
    logic             wr_en, rd_en;

    // a pop frees the slot in the same cycle, so a full FIFO still accepts a push
    assign rd_en  = pop & ~empty;
    assign wr_en  = push & (~full | rd_en);
    assign wr_nxt = wr_ptr + PW'(wr_en);
    assign rd_nxt = rd_ptr + PW'(rd_en);

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

endmodule

// File: rtl/sensor_frame_hub.sv
// Sensor frame hub: captures NUM_CH sensor words on each end_i rising edge into a
// frame FIFO and exposes it, CPU result registers and a level irq over Avalon-MM.
module sensor_frame_hub
    import sensor_hub_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned NUM_OUT = 3,
    parameter int unsigned OUT_W   = 8
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [NUM_CH*DATA_W-1:0]  sample_i,
    input  logic                      end_i,
    input  logic [5:0]                avs_address,
    input  logic                      avs_read,
    input  logic                      avs_write,
    input  logic [31:0]               avs_writedata,
    output logic [31:0]               avs_readdata,
    output logic [NUM_OUT*OUT_W-1:0]  result_o,
    output logic                      irq_o
);

    localparam int unsigned FW = NUM_CH * DATA_W;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic             end_q;
    logic             capture_en;
    logic [7:0]       thresh;
    logic             ovf, udf;
    logic [15:0]      drop_cnt;
    logic [OUT_W-1:0] out_reg [NUM_OUT];

    logic [FW-1:0]    head;
    logic [LW-1:0]    level;
    logic             full, empty;

    logic             wr_ctrl, wr_clear, pop_req, push_req;
    logic             ovf_evt, udf_evt;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    assign unused_wd = ^avs_writedata;

    assign wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
    assign wr_clear = avs_write && (avs_address == ADDR_CLEAR);
    assign pop_req  = avs_write && (avs_address == ADDR_POP);
    assign push_req = end_i && !end_q && capture_en;

    // full plus a pop is not a drop: the pop makes room for the push
    assign ovf_evt = push_req && full && !pop_req;
    assign udf_evt = pop_req && empty;

    sync_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (push_req),
        .pop   (pop_req),
        .din   (sample_i),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_STATUS: begin
                rd_mux[7:0]      = 8'(level);
                rd_mux[ST_EMPTY] = empty;
                rd_mux[ST_FULL]  = full;
                rd_mux[ST_OVF]   = ovf;
                rd_mux[ST_UDF]   = udf;
            end
            ADDR_CTRL: begin
                rd_mux[CTRL_CAP_EN]                      = capture_en;
                rd_mux[CTRL_THRESH_LSB +: 8]             = thresh;
            end
            ADDR_DROP_CNT: rd_mux[15:0] = drop_cnt;
            default: ;
        endcase
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (avs_address == ADDR_OUT0 + 6'(k))
                rd_mux = 32'(out_reg[k]);
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!empty && avs_address == ADDR_FRAME0 + 6'(c))
                rd_mux = 32'(head[c*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        result_o = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++)
            result_o[k*OUT_W +: OUT_W] = out_reg[k];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            end_q        <= 1'b0;
            capture_en   <= 1'b1;
            thresh       <= 8'd1;
            ovf          <= 1'b0;
            udf          <= 1'b0;
            drop_cnt     <= '0;
            irq_o        <= 1'b0;
            avs_readdata <= '0;
            for (int unsigned k = 0; k < NUM_OUT; k++)
                out_reg[k] <= '0;
        end else begin
            end_q <= end_i;

            if (wr_ctrl) begin
                capture_en <= avs_writedata[CTRL_CAP_EN];
                thresh     <= avs_writedata[CTRL_THRESH_LSB +: 8];
            end

            // a same-cycle event overrides the clear
            ovf <= ovf_evt || (ovf && !(wr_clear && avs_writedata[CLR_OVF]));
            udf <= udf_evt || (udf && !(wr_clear && avs_writedata[CLR_UDF]));

            if (wr_clear && avs_writedata[CLR_DROP])
                drop_cnt <= ovf_evt ? 16'd1 : 16'd0;
            else if (ovf_evt && drop_cnt != '1)
                drop_cnt <= drop_cnt + 16'd1;

            irq_o <= capture_en && (thresh != '0) && (16'(level) >= 16'(thresh));

            if (avs_read)
                avs_readdata <= rd_mux;

            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                if (avs_write && avs_address == ADDR_OUT0 + 6'(k))
                    out_reg[k] <= avs_writedata[OUT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sensor_frame_hub.sv
// Directed bench for sensor_frame_hub with hand-computed expectations.
module tb_sensor_frame_hub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] sample_i;
    logic        end_i;
    logic [5:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [23:0] result_o;
    logic        irq_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    sensor_frame_hub #(
        .NUM_CH  (2),
        .DATA_W  (24),
        .DEPTH   (16),
        .NUM_OUT (3),
        .OUT_W   (8)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sample_i      (sample_i),
        .end_i         (end_i),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .result_o      (result_o),
        .irq_o         (irq_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic avs_rd(input logic [5:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic avs_wr(input logic [5:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic pulse_end(input logic [47:0] s);
        sample_i = s;
        end_i    = 1'b1;
        tick();
        end_i    = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; sample_i = '0; end_i = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        tick(); tick();
        chk("rst_irq", 32'(irq_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1. reset state
        avs_rd(6'd0, rd); chk("status_reset", rd, 32'h100);
        avs_rd(6'd1, rd); chk("ctrl_reset", rd, 32'h101);
        chk("irq_reset", 32'(irq_o), 32'h0);
        chk("result_reset", 32'(result_o), 32'h0);
        tick();
        chk("readdata_hold", avs_readdata, 32'h101);

        // 2. single frame, readback, pop, underflow
        pulse_end({24'h0000AA, 24'h123456});
        avs_rd(6'd0, rd);  chk("status_one", rd, 32'h001);
        avs_rd(6'd32, rd); chk("frame0", rd, 32'h00123456);
        avs_rd(6'd33, rd); chk("frame1", rd, 32'h000000AA);
        avs_rd(6'd34, rd); chk("frame_oor", rd, 32'h0);
        avs_rd(6'd5, rd);  chk("unmapped", rd, 32'h0);
        avs_wr(6'd3, 32'h0);
        avs_rd(6'd0, rd);  chk("status_popped", rd, 32'h100);
        avs_rd(6'd32, rd); chk("frame_empty", rd, 32'h0);
        avs_wr(6'd3, 32'h0);
        avs_rd(6'd0, rd);  chk("status_udf", rd, 32'h900);
        avs_wr(6'd2, 32'h2);
        avs_rd(6'd0, rd);  chk("status_udf_clr", rd, 32'h100);

        // 3. overflow: 17 edges into 16 slots
        for (int i = 0; i < 17; i++)
            pulse_end({24'(i + 256), 24'(i)});
        avs_rd(6'd0, rd); chk("status_ovf", rd, 32'h610);
        avs_rd(6'd4, rd); chk("drop_one", rd, 32'h1);
        chk("irq_full", 32'(irq_o), 32'h1);
        avs_wr(6'd2, 32'h5);
        avs_rd(6'd0, rd); chk("status_ovf_clr", rd, 32'h210);
        avs_rd(6'd4, rd); chk("drop_clr", rd, 32'h0);

        // 4. simultaneous pop and push while full
        sample_i      = {24'h000777, 24'h00BEEF};
        end_i         = 1'b1;
        avs_address   = 6'd3;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        end_i         = 1'b0;
        tick();
        avs_rd(6'd0, rd);  chk("status_pp_full", rd, 32'h210);
        avs_rd(6'd4, rd);  chk("drop_pp_full", rd, 32'h0);
        avs_rd(6'd32, rd); chk("head_after_pp", rd, 32'h1);
        for (int i = 0; i < 15; i++)
            avs_wr(6'd3, 32'h0);
        avs_rd(6'd32, rd); chk("tail_frame0", rd, 32'h00BEEF);
        avs_rd(6'd33, rd); chk("tail_frame1", rd, 32'h000777);
        avs_rd(6'd0, rd);  chk("status_last", rd, 32'h001);
        avs_wr(6'd3, 32'h0);
        avs_rd(6'd0, rd);  chk("status_drained", rd, 32'h100);

        // 5. threshold interrupt
        avs_wr(6'd1, 32'h0401);
        avs_rd(6'd1, rd); chk("ctrl_thresh4", rd, 32'h401);
        for (int i = 0; i < 3; i++)
            pulse_end(48'(i + 1));
        tick();
        chk("irq_lvl3", 32'(irq_o), 32'h0);
        pulse_end(48'h4);
        chk("irq_lvl4", 32'(irq_o), 32'h1);
        avs_wr(6'd3, 32'h0);
        tick();
        chk("irq_after_pop", 32'(irq_o), 32'h0);
        avs_wr(6'd1, 32'h0400);
        pulse_end(48'h5);
        avs_rd(6'd0, rd); chk("status_cap_off", rd, 32'h003);
        avs_wr(6'd1, 32'h0001);
        tick(); tick();
        chk("irq_thresh0", 32'(irq_o), 32'h0);
        avs_wr(6'd1, 32'h0301);
        tick(); tick();
        chk("irq_eq_thresh", 32'(irq_o), 32'h1);

        // 6. result registers and asynchronous reset
        avs_wr(6'd17, 32'h5A);
        chk("result_out1", 32'(result_o), 32'h005A00);
        avs_wr(6'd16, 32'h1FF);
        chk("result_out0", 32'(result_o), 32'h005AFF);
        avs_rd(6'd17, rd); chk("out1_read", rd, 32'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_result", 32'(result_o), 32'h0);
        chk("async_irq", 32'(irq_o), 32'h0);
        chk("async_readdata", avs_readdata, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        avs_rd(6'd0, rd); chk("status_post_rst", rd, 32'h100);
        avs_rd(6'd1, rd); chk("ctrl_post_rst", rd, 32'h101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
